// File: rtl/spi_slave_param.sv
// SPI-style serial slave: command-tagged frames in on MOSI, read data back out on MISO.
// Tracks whether a read address preceded a read-data request across frames.
module spi_slave_param #(
    parameter int DATA_W = 8,
    parameter int CMD_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    SS_n,
    input  logic                    MOSI,
    output logic                    MISO,
    output logic [DATA_W+CMD_W-1:0] rx_data,
    output logic                    rx_valid,
    input  logic [DATA_W-1:0]       tx_data,
    input  logic                    tx_valid,
    output logic                    busy,
    output logic                    frame_err
);

    localparam int FRAME_W = DATA_W + CMD_W;
    localparam int CNT_W   = $clog2(DATA_W + 3);
    localparam int TXC_W   = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] DONE    = CNT_W'(FRAME_W);
    localparam logic [TXC_W-1:0] TX_BITS = TXC_W'(DATA_W);

    typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;
    state_t state, state_nxt;

    logic [CNT_W-1:0]   cnt;
    logic [FRAME_W-2:0] shreg;
    logic               rd_addr_seen;
    logic               tx_taken;
    logic [DATA_W-1:0]  tx_sr;
    logic [TXC_W-1:0]   tx_left;
    logic               shifting, frame_done, last_bit, take_bit, load_tx;

    // cnt saturates at DONE, which doubles as the "frame complete, ignore MOSI" marker
    assign shifting   = state inside {WRITE, READ_ADD, READ_DATA};
    assign frame_done = (cnt == DONE);
    assign last_bit   = shifting && (cnt == LAST);
    assign take_bit   = shifting && !frame_done && (!SS_n || last_bit);
    assign load_tx    = (state == READ_DATA) && frame_done && !tx_taken && tx_valid && !SS_n;

    assign busy = (state != IDLE);
    assign MISO = (tx_left != '0) && tx_sr[DATA_W-1];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!SS_n) state_nxt = CHK_CMD;
            end
            CHK_CMD: begin
                if (SS_n)              state_nxt = IDLE;
                else if (!MOSI)        state_nxt = WRITE;
                else if (rd_addr_seen) state_nxt = READ_DATA;
                else                   state_nxt = READ_ADD;
            end
            default: begin
                if (SS_n) state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            shreg        <= '0;
            rd_addr_seen <= 1'b0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            frame_err    <= 1'b0;
            tx_taken     <= 1'b0;
            tx_sr        <= '0;
            tx_left      <= '0;
        end else begin
            state     <= state_nxt;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;

            if (take_bit) begin
                shreg <= {shreg[FRAME_W-3:0], MOSI};
                cnt   <= cnt + CNT_W'(1);
                if (last_bit) begin
                    rx_data  <= {shreg, MOSI};
                    rx_valid <= 1'b1;
                    if (state == READ_ADD)  rd_addr_seen <= 1'b1;
                    if (state == READ_DATA) rd_addr_seen <= 1'b0;
                end
            end

            if (load_tx) begin
                tx_sr    <= tx_data;
                tx_left  <= TX_BITS;
                tx_taken <= 1'b1;
            end else if (tx_left != '0) begin
                tx_sr   <= tx_sr << 1;
                tx_left <= tx_left - TXC_W'(1);
            end

            // placed last so a deselect overrides the counter/shift updates above
            if (state != IDLE && SS_n) begin
                cnt       <= '0;
                tx_left   <= '0;
                tx_taken  <= 1'b0;
                frame_err <= !frame_done && !last_bit;
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_param.sv
// Directed + randomized bench for spi_slave_param (DATA_W=8 and DATA_W=16 instances).
// Expected values come from a frame-level model: received word, read-address flag, tx bits.
module tb_spi_slave_param;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        SS_n = 1'b1;
    logic        MOSI = 1'b0;
    logic        tx_valid = 1'b0;
    logic [7:0]  tx_data = '0;
    logic        MISO, rx_valid, busy, frame_err;
    logic [9:0]  rx_data;

    logic [15:0] tx_data16 = '0;
    logic        tx_valid16 = 1'b0;
    logic        miso16, rx_valid16, busy16, frame_err16;
    logic [17:0] rx_data16;

    int checks = 0;
    int errors = 0;

    logic [9:0] exp_rx = '0;
    bit         rd_seen = 1'b0;

    always #5 clk = ~clk;

    spi_slave_param #(.DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data),
        .tx_valid(tx_valid), .busy(busy), .frame_err(frame_err)
    );

    spi_slave_param #(.DATA_W(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .MOSI(MOSI), .MISO(miso16),
        .rx_data(rx_data16), .rx_valid(rx_valid16), .tx_data(tx_data16),
        .tx_valid(tx_valid16), .busy(busy16), .frame_err(frame_err16)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic sel);
        SS_n = 1'b0;
        MOSI = 1'b0;
        step();
        MOSI = sel;
        step();
    endtask

    task automatic send_bits(input logic [33:0] w, input int n, input bit raise_last, input bit wide);
        for (int i = n - 1; i >= 0; i--) begin
            MOSI = w[i];
            if (i == 0 && raise_last) SS_n = 1'b1;
            step();
            if (i > 0) begin
                if (wide) check("rxv16_mid", rx_valid16, 1'b0);
                else      check("rxv_mid", rx_valid, 1'b0);
            end
        end
    endtask

    task automatic frame8(input logic sel, input logic [9:0] w, input bit raise_last);
        start_frame(sel);
        check("busy_frame", busy, 1'b1);
        send_bits({24'b0, w}, 10, raise_last, 1'b0);
        check("rx_valid", rx_valid, 1'b1);
        check("rx_data", rx_data, w);
        check("ferr_frame", frame_err, 1'b0);
        exp_rx = w;
    endtask

    task automatic miso_phase(input bit expect_shift, input logic [7:0] tx, input int unsigned wait_cyc);
        repeat (wait_cyc) begin
            step();
            check("miso_wait", MISO, 1'b0);
        end
        tx_data  = tx;
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        tx_data  = ~tx;
        for (int i = 7; i >= 0; i--) begin
            check("miso_bit", MISO, expect_shift ? tx[i] : 1'b0);
            step();
        end
        check("miso_after", MISO, 1'b0);
    endtask

    task automatic end_frame();
        SS_n = 1'b1;
        step();
        check("busy_end", busy, 1'b0);
        check("ferr_end", frame_err, 1'b0);
        check("miso_end", MISO, 1'b0);
        check("rx_hold", rx_data, exp_rx);
        check("rxv_end", rx_valid, 1'b0);
    endtask

    task automatic ensure_rd_seen();
        if (!rd_seen) begin
            frame8(1'b1, 10'($urandom), 1'b0);
            miso_phase(1'b0, 8'($urandom), 0);
            rd_seen = 1'b1;
            end_frame();
        end
    endtask

    initial begin
        logic [9:0]  w;
        logic        sel;
        logic [17:0] w16;
        logic [7:0]  tx;

        // reset values
        repeat (3) step();
        check("rst_rx_data", rx_data, 10'h0);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_miso", MISO, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ferr", frame_err, 1'b0);
        check("rst_rx_data16", rx_data16, 18'h0);
        check("rst_busy16", busy16 | frame_err16 | rx_valid16 | miso16, 1'b0);
        rst_n = 1'b1;
        step();
        check("idle_busy", busy, 1'b0);

        // write address, then extra MOSI activity after completion is ignored
        frame8(1'b0, 10'h0A5, 1'b0);
        for (int k = 0; k < 5; k++) begin
            MOSI = 1'($urandom);
            step();
            check("rxv_after", rx_valid, 1'b0);
            check("rx_ignore", rx_data, exp_rx);
        end
        end_frame();

        // read address, then read data with C3 arriving 3 cycles late
        frame8(1'b1, 10'h203, 1'b0);
        miso_phase(1'b0, 8'($urandom), 0);
        rd_seen = 1'b1;
        end_frame();
        frame8(1'b1, {2'b11, 8'($urandom)}, 1'b0);
        miso_phase(1'b1, 8'hC3, 3);
        rd_seen = 1'b0;
        end_frame();

        // read with no prior address must be treated as address phase
        frame8(1'b1, 10'h300, 1'b0);
        miso_phase(1'b0, 8'($urandom), 1);
        rd_seen = 1'b1;
        end_frame();

        // random frame mix against the frame-level model
        for (int k = 0; k < 10; k++) begin
            sel = 1'($urandom);
            w   = 10'($urandom);
            tx  = 8'($urandom);
            frame8(sel, w, 1'b0);
            miso_phase(sel && rd_seen, tx, $urandom_range(0, 4));
            if (sel) rd_seen = !rd_seen;
            end_frame();
        end

        // abort after 5 payload bits leaves data and read-address flag intact
        ensure_rd_seen();
        start_frame(1'b1);
        send_bits({24'b0, 10'($urandom)}, 5, 1'b0, 1'b0);
        SS_n = 1'b1;
        step();
        check("abort_ferr", frame_err, 1'b1);
        check("abort_rxv", rx_valid, 1'b0);
        check("abort_rx", rx_data, exp_rx);
        check("abort_busy", busy, 1'b0);
        step();
        check("abort_ferr_pulse", frame_err, 1'b0);
        frame8(1'b1, 10'($urandom), 1'b0);
        miso_phase(1'b1, 8'($urandom), 2);
        rd_seen = 1'b0;
        end_frame();

        // abort during the command cycle
        SS_n = 1'b0;
        step();
        SS_n = 1'b1;
        step();
        check("chk_abort_ferr", frame_err, 1'b1);
        check("chk_abort_busy", busy, 1'b0);
        step();

        // deselect coincident with the final bit still completes the frame
        w = 10'($urandom);
        frame8(1'b0, w, 1'b1);
        check("last_ss_busy", busy, 1'b0);
        step();
        check("last_ss_ferr", frame_err, 1'b0);
        check("last_ss_rxv", rx_valid, 1'b0);

        // deselect while MISO is shifting
        ensure_rd_seen();
        frame8(1'b1, 10'($urandom), 1'b0);
        rd_seen = 1'b0;
        tx = 8'($urandom);
        tx_data = tx;
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        check("ss_miso7", MISO, tx[7]);
        step();
        check("ss_miso6", MISO, tx[6]);
        SS_n = 1'b1;
        step();
        check("ss_miso_stop", MISO, 1'b0);
        check("ss_busy", busy, 1'b0);
        check("ss_ferr", frame_err, 1'b0);
        step();
        check("ss_miso_stay", MISO, 1'b0);

        // reset in the middle of MISO shifting
        ensure_rd_seen();
        frame8(1'b1, 10'($urandom), 1'b0);
        tx = 8'($urandom);
        tx_data = tx;
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        repeat (4) step();
        check("pre_rst_miso3", MISO, tx[3]);
        rst_n = 1'b0;
        SS_n  = 1'b1;
        step();
        check("mrst_miso", MISO, 1'b0);
        check("mrst_rx", rx_data, 10'h0);
        check("mrst_rxv", rx_valid, 1'b0);
        check("mrst_busy", busy, 1'b0);
        check("mrst_ferr", frame_err, 1'b0);
        rst_n = 1'b1;
        rd_seen = 1'b0;
        exp_rx = '0;
        step();
        frame8(1'b1, 10'($urandom), 1'b0);
        miso_phase(1'b0, 8'($urandom), 0);
        rd_seen = 1'b1;
        end_frame();

        // 16-bit payload instance: 18-bit write frame
        w16 = 18'($urandom);
        start_frame(1'b0);
        check("busy16", busy16, 1'b1);
        send_bits({16'b0, w16}, 18, 1'b0, 1'b1);
        check("rxv16", rx_valid16, 1'b1);
        check("rx16", rx_data16, w16);
        check("rx16_cmd", rx_data16[17:16], w16[17:16]);
        step();
        check("rxv16_pulse", rx_valid16, 1'b0);
        SS_n = 1'b1;
        step();
        check("ferr16_end", frame_err16, 1'b0);
        check("busy16_end", busy16, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_slave_param.md
SPI_SLAVE_PARAM -- requirements
Module: spi_slave_param

Interface
REQ-001 Parameter DATA_W, default 8, payload width in bits; legal range 4..32.
REQ-002 Parameter CMD_W, fixed 2, command field width carried in front of each payload.
REQ-003 Port clk, input, 1, single clock; all logic samples on its rising edge.
REQ-004 Port rst_n, input, 1, synchronous active-low reset.
REQ-005 Port SS_n, input, 1, active-low slave select; high ends any frame.
REQ-006 Port MOSI, input, 1, serial data in, MSB first.
REQ-007 Port MISO, output, 1, serial read data out, MSB first.
REQ-008 Port rx_data, output, DATA_W+CMD_W, received word; command in the top CMD_W bits (00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data).
REQ-009 Port rx_valid, output, 1, one-cycle strobe marking a new rx_data.
REQ-010 Port tx_data, input, DATA_W, read data to be returned.
REQ-011 Port tx_valid, input, 1, qualifies tx_data.
REQ-012 Port busy, output, 1, high in every state except IDLE.
REQ-013 Port frame_err, output, 1, one-cycle strobe for a frame aborted before completion.

Function
REQ-014 The state machine SHALL have states IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
REQ-015 IDLE: SS_n=0 -> CHK_CMD on the next cycle; otherwise stay in IDLE.
REQ-016 CHK_CMD samples the selector bit on MOSI; this bit is not stored. Transitions: MOSI=0 -> WRITE; MOSI=1 and rd_addr_seen=0 -> READ_ADD; MOSI=1 and rd_addr_seen=1 -> READ_DATA.
REQ-017 In WRITE, READ_ADD and READ_DATA the block SHALL shift DATA_W+2 MOSI bits MSB-first into a shift register, counting with a counter of width clog2(DATA_W+3).
REQ-018 The cycle after the (DATA_W+2)th bit is sampled: rx_data SHALL load the full shift register and rx_valid SHALL be 1 for exactly one cycle.
REQ-019 rx_data SHALL hold its value until the next completed frame.
REQ-020 After rx_valid, further MOSI bits are ignored until SS_n=1.
REQ-021 On rx_valid in READ_ADD, rd_addr_seen SHALL be set to 1.
REQ-022 On rx_valid in READ_DATA, rd_addr_seen SHALL be cleared to 0.
REQ-023 After rx_valid in READ_DATA, the block SHALL wait (any number of cycles) for tx_valid=1, then latch tx_data.
REQ-024 On the DATA_W cycles following the tx_data latch, MISO SHALL drive the latched bits MSB first, one bit per cycle.
REQ-025 MISO SHALL be 0 at all other times.
REQ-026 tx_valid SHALL be ignored outside the READ_DATA wait phase.
REQ-027 SS_n=1 in any non-IDLE state SHALL move the state machine to IDLE on the next cycle and clear the bit counter.
REQ-028 If that SS_n=1 arrives before rx_valid was produced, frame_err SHALL pulse for one cycle, rx_data SHALL remain unchanged, and rd_addr_seen SHALL remain unchanged.
REQ-029 If SS_n rises during MISO shifting, shifting SHALL stop and MISO SHALL return to 0.
REQ-030 If SS_n=1 and the final bit occur on the same cycle, the bit SHALL be accepted, rx_valid SHALL pulse, and frame_err SHALL stay 0.

Reset
REQ-031 rst_n=0 at a clock edge SHALL force the following: state IDLE, counter 0, rd_addr_seen 0, rx_data 0, rx_valid 0, MISO 0, busy 0, frame_err 0.
REQ-032 Reset SHALL take priority over every other event, including mid-frame and mid-MISO shifting.

Verification (DATA_W=8)
REQ-033 Write address -- SS_n low; MOSI 0, then 00_1010_0101 -> rx_data=10'h0A5; rx_valid high for one cycle 11 cycles after CHK_CMD; busy=1.
REQ-034 Read address then read data -- frame 1,10_0000_0011 -> rx_data=10'h203, rd_addr_seen=1. Then SS_n high and low again; frame 1,11_xxxx_xxxx -> READ_DATA, rx_valid. Then tx_valid with tx_data=8'hC3 3 cycles later -> MISO sequence 1,1,0,0,0,0,1,1, then 0; rd_addr_seen=0.
REQ-035 Read without prior address -- after reset, frame 1,11_0000_0000 -> enters READ_ADD, not READ_DATA.
REQ-036 Abort -- SS_n rises after 5 payload bits -> frame_err single pulse, no rx_valid, rx_data unchanged, IDLE next cycle.
REQ-037 Reset mid-read -- rst_n=0 during MISO bit 3 -> MISO=0 and all outputs at reset values on the next cycle; a subsequent read frame enters READ_ADD.
REQ-038 Parameter sweep -- DATA_W=16, write frame of 18 bits -> rx_valid after bit 18; rx_data[17:16]=command.
